// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter
// Lets NUM_REQ decoded-posit term streams share one quire accumulator, one
// complete window (sow..eow) at a time, using round-robin ownership. Every
// granted window is tagged with its requester id in a small FIFO. That id is
// released in order when the quire reports the window's eow result beat.
//
// state | meaning
// IDLE  | no owner; choose the next sow-bearing requester (one decision cycle)
// OWN   | owner's beats go through to the quire until an eow beat transfers
module quire_window_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_rts_i,
    output logic [NUM_REQ-1:0]   req_rtr_o,
    input  logic [NUM_REQ-1:0]   req_sow_i,
    input  logic [NUM_REQ-1:0]   req_eow_i,
    input  logic [4*NUM_REQ-1:0] req_fraction_i,
    input  logic [4*NUM_REQ-1:0] req_scale_i,
    input  logic [NUM_REQ-1:0]   req_sign_i,
    input  logic [NUM_REQ-1:0]   req_zero_i,
    input  logic [NUM_REQ-1:0]   req_NaR_i,
    output logic                 q_rts_o,
    input  logic                 q_rtr_i,
    output logic                 q_sow_o,
    output logic                 q_eow_o,
    output logic [3:0]           q_fraction_o,
    output logic [3:0]           q_scale_o,
    output logic                 q_sign_o,
    output logic                 q_zero_o,
    output logic                 q_NaR_o,
    input  logic                 res_beat_i,
    input  logic                 res_eow_i,
    output logic [ID_W-1:0]      res_id_o,
    output logic                 res_id_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    cand;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               underflow;
    logic               owner_rts;
    logic               owner_eow;
    logic               xfer;

    // The requester index base+off wraps modulo NUM_REQ. NUM_REQ does not have to be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    assign eligible   = req_rts_i & req_sow_i;
    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign owner_rts  = req_rts_i[owner_q];
    assign owner_eow  = req_eow_i[owner_q];
    assign xfer       = (state_q == OWN) && owner_rts && q_rtr_i;
    assign pop        = res_beat_i && res_eow_i && !fifo_empty;
    assign underflow  = res_beat_i && res_eow_i && fifo_empty;

    // Round-robin search: pick the first eligible requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr_q, i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next state. A grant happens only when the tag FIFO has room. Ownership ends on a transferred eow beat.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !fifo_full) begin
                    state_d = OWN;
                    owner_d = pick;
                    push    = 1'b1;
                end
            end
            OWN: begin
                if (xfer && owner_eow) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_add(owner_q, 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux. Only the owner can see the quire; every output stays 0 while idle.
    always_comb begin
        req_rtr_o    = '0;
        q_rts_o      = 1'b0;
        q_sow_o      = 1'b0;
        q_eow_o      = 1'b0;
        q_fraction_o = '0;
        q_scale_o    = '0;
        q_sign_o     = 1'b0;
        q_zero_o     = 1'b0;
        q_NaR_o      = 1'b0;
        if (state_q == OWN) begin
            req_rtr_o[owner_q] = q_rtr_i;
            q_rts_o            = owner_rts;
            q_sow_o            = req_sow_i[owner_q];
            q_eow_o            = owner_eow;
            q_fraction_o       = req_fraction_i[{owner_q, 2'b00} +: 4];
            q_scale_o          = req_scale_i[{owner_q, 2'b00} +: 4];
            q_sign_o           = req_sign_i[owner_q];
            q_zero_o           = req_zero_i[owner_q];
            q_NaR_o            = req_NaR_i[owner_q];
        end
    end

    // FSM registers and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tag FIFO pointers and count. If a push and a pop happen together, the count does not change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Tag storage. It has no reset because the count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= owner_d;
        end
    end

    // Sticky flag: the quire returned a result eow that no granted window accounts for.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (underflow) begin
            err_q <= 1'b1;
        end
    end

    assign res_id_valid_o = !fifo_empty;
    assign res_id_o       = fifo_empty ? '0 : tag_mem_q[rd_ptr_q];
    assign busy_o         = (state_q == OWN);
    assign err_o          = err_q;

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Testbench for quire_window_arbiter. Requester sources are modelled as beat
// queues. Expected quire-side beats sit in a scoreboard queue and are popped
// when the DUT transfers a beat.
module tb_quire_window_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TD  = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_rts_i;
    logic [N-1:0]   req_rtr_o;
    logic [N-1:0]   req_sow_i;
    logic [N-1:0]   req_eow_i;
    logic [4*N-1:0] req_fraction_i;
    logic [4*N-1:0] req_scale_i;
    logic [N-1:0]   req_sign_i;
    logic [N-1:0]   req_zero_i;
    logic [N-1:0]   req_NaR_i;
    logic           q_rts_o;
    logic           q_rtr_i;
    logic           q_sow_o;
    logic           q_eow_o;
    logic [3:0]     q_fraction_o;
    logic [3:0]     q_scale_o;
    logic           q_sign_o;
    logic           q_zero_o;
    logic           q_NaR_o;
    logic           res_beat_i;
    logic           res_eow_i;
    logic [IDW-1:0] res_id_o;
    logic           res_id_valid_o;
    logic           busy_o;
    logic           err_o;

    quire_window_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o),
        .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
        .req_fraction_i(req_fraction_i), .req_scale_i(req_scale_i),
        .req_sign_i(req_sign_i), .req_zero_i(req_zero_i), .req_NaR_i(req_NaR_i),
        .q_rts_o(q_rts_o), .q_rtr_i(q_rtr_i),
        .q_sow_o(q_sow_o), .q_eow_o(q_eow_o),
        .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
        .q_sign_o(q_sign_o), .q_zero_o(q_zero_o), .q_NaR_o(q_NaR_o),
        .res_beat_i(res_beat_i), .res_eow_i(res_eow_i),
        .res_id_o(res_id_o), .res_id_valid_o(res_id_valid_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sow;
        logic       eow;
        logic [3:0] frac;
        logic [3:0] scale;
        logic       sign;
        logic       zero;
        logic       nar;
    } beat_t;

    typedef struct {
        int         id;
        int         nbeats;
        logic [3:0] base;
        logic [7:0] stall_mask;   // bit j set: q_rtr_i=0 in OWN cycle j
        int         exp_cycles;
    } win_vec_t;

    beat_t    src_q [N][$];
    beat_t    exp_q [$];
    win_vec_t tbl [5];
    int       n_checks = 0;
    int       n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic load_window(input int id, input int n, input logic [3:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sow   = (i == 0);
            b.eow   = (i == n - 1);
            b.frac  = base + 4'(i);
            b.scale = ~(base + 4'(i));
            b.sign  = (i % 2) == 1;
            b.zero  = (i == 1);
            b.nar   = (id == 3);
            src_q[id].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle. Drive at negedge, then sample 1 time unit later, well before the next posedge.
    task automatic step(input logic rtr, input logic rb, input logic re, input logic rstv);
        beat_t act;
        beat_t e;
        @(negedge clk);
        rst_n      = rstv;
        q_rtr_i    = rtr;
        res_beat_i = rb;
        res_eow_i  = re;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                e = src_q[k][0];
                req_rts_i[k]          = 1'b1;
                req_sow_i[k]          = e.sow;
                req_eow_i[k]          = e.eow;
                req_fraction_i[4*k +: 4] = e.frac;
                req_scale_i[4*k +: 4]    = e.scale;
                req_sign_i[k]         = e.sign;
                req_zero_i[k]         = e.zero;
                req_NaR_i[k]          = e.nar;
            end else begin
                req_rts_i[k]          = 1'b0;
                req_sow_i[k]          = 1'b0;
                req_eow_i[k]          = 1'b0;
                req_fraction_i[4*k +: 4] = 4'h0;
                req_scale_i[4*k +: 4]    = 4'h0;
                req_sign_i[k]         = 1'b0;
                req_zero_i[k]         = 1'b0;
                req_NaR_i[k]          = 1'b0;
            end
        end
        #1;
        if (rstv) begin
            if (q_rts_o && q_rtr_i) begin
                act = {q_sow_o, q_eow_o, q_fraction_o, q_scale_o, q_sign_o, q_zero_o, q_NaR_o};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL q_beat_unexpected: got %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("q_beat", 32'(act), 32'(e));
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req_rts_i[k] && req_rtr_o[k]) begin
                    e = src_q[k].pop_front();
                end
            end
        end
    endtask

    initial begin
        int  j;
        int  id;
        logic rtr;
        int  pop_ids [4];

        tbl[0] = '{0, 3, 4'h1, 8'h00, 4};   // plain 3-beat window
        tbl[1] = '{1, 1, 4'h5, 8'h00, 2};   // single-beat window (sow=eow)
        tbl[2] = '{3, 3, 4'h8, 8'h02, 5};   // rtr 1,0,1 in the middle of the window
        tbl[3] = '{2, 2, 4'hC, 8'h00, 3};
        tbl[4] = '{1, 2, 4'h6, 8'h05, 5};   // stall on the first beat and the last beat

        rst_n = 1'b0; q_rtr_i = 1'b0; res_beat_i = 1'b0; res_eow_i = 1'b0;
        req_rts_i = '0; req_sow_i = '0; req_eow_i = '0; req_fraction_i = '0;
        req_scale_i = '0; req_sign_i = '0; req_zero_i = '0; req_NaR_i = '0;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_q_rts", 32'(q_rts_o), 0);
        chk("rst_req_rtr", 32'(req_rtr_o), 0);
        chk("rst_id_valid", 32'(res_id_valid_o), 0);
        chk("rst_err", 32'(err_o), 0);

        // Table-driven single windows. Each window is followed by its result eow pop.
        for (int t = 0; t < 5; t++) begin
            id = tbl[t].id;
            load_window(id, tbl[t].nbeats, tbl[t].base);
            j = 0;
            do begin
                rtr = (j == 0) ? 1'b1 : ~tbl[t].stall_mask[(j - 1) % 8];
                step(rtr, 1'b0, 1'b0, 1'b1);
                if (j == 0) begin
                    chk("decision_cycle_busy", 32'(busy_o), 0);
                    chk("decision_cycle_q_rts", 32'(q_rts_o), 0);
                end else begin
                    chk("own_busy", 32'(busy_o), 1);
                    chk("owner_rtr", 32'(req_rtr_o), 32'(rtr) << id);
                end
                j++;
            end while (!(src_q[id].size() == 0 && exp_q.size() == 0) && j < 20);
            chk("window_cycles", j, tbl[t].exp_cycles);
            step(1'b1, 1'b0, 1'b0, 1'b1);
            chk("idle_after_eow", 32'(busy_o), 0);
            chk("tag_valid", 32'(res_id_valid_o), 1);
            chk("tag_id", 32'(res_id_o), id);
            step(1'b1, 1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b0, 1'b1);
            chk("tag_popped", 32'(res_id_valid_o), 0);
        end

        // A result eow arrives with the tag FIFO empty.
        chk("err_before", 32'(err_o), 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("err_set", 32'(err_o), 1);
        chk("err_no_valid", 32'(res_id_valid_o), 0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("err_sticky", 32'(err_o), 1);

        // Reset lands in the middle of req2's window.
        load_window(2, 3, 4'h3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r6_grant_busy", 32'(busy_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r6_own_busy", 32'(busy_o), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        src_q[2].delete();
        exp_q.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r6_busy", 32'(busy_o), 0);
        chk("r6_q_rts", 32'(q_rts_o), 0);
        chk("r6_req_rtr", 32'(req_rtr_o), 0);
        chk("r6_id_valid", 32'(res_id_valid_o), 0);
        chk("r6_err", 32'(err_o), 0);
        chk("r6_q_data", 32'({q_sow_o, q_eow_o, q_fraction_o, q_scale_o, q_sign_o, q_zero_o, q_NaR_o}), 0);

        // All four requesters present sow at once. Expect grants in order 0..3, each followed by a bubble.
        for (int k = 0; k < N; k++) load_window(k, 1, 4'(3 * k + 2));
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            chk("rr_busy", 32'(busy_o), c % 2);
            if (c % 2 == 1) chk("rr_owner_rtr", 32'(req_rtr_o), 32'(1) << (c / 2));
        end
        chk("rr_drained", exp_q.size(), 0);

        // Tag FIFO is now full. Req0 (wrapped pointer) must wait until one tag is popped.
        load_window(0, 1, 4'hE);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            chk("full_stall_busy", 32'(busy_o), 0);
            chk("full_stall_rtr", 32'(req_rtr_o), 0);
        end
        chk("full_head_valid", 32'(res_id_valid_o), 1);
        chk("full_head_id", 32'(res_id_o), 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("full_pop_cycle_busy", 32'(busy_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("full_grant_cycle_busy", 32'(busy_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("full_own_busy", 32'(busy_o), 1);
        chk("full_drained", exp_q.size(), 0);
        pop_ids = '{1, 2, 3, 0};
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            chk("tag_order_valid", 32'(res_id_valid_o), 1);
            chk("tag_order_id", 32'(res_id_o), pop_ids[p]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("tags_empty", 32'(res_id_valid_o), 0);

        // A push (grant) and a pop in the same cycle
        load_window(1, 1, 4'h9);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        load_window(2, 1, 4'hB);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("pp_head_before", 32'(res_id_o), 1);
        chk("pp_grant_busy", 32'(busy_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_own_busy", 32'(busy_o), 1);
        chk("pp_valid_after", 32'(res_id_valid_o), 1);
        chk("pp_head_after", 32'(res_id_o), 2);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_empty", 32'(res_id_valid_o), 0);
        chk("pp_drained", exp_q.size(), 0);
        chk("final_err", 32'(err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
